// File: rtl/gb_apu_pkg.sv
// Shared types and per-step decode tables for the APU frame sequencer.
// Bit N of each mask is set when step N produces that pulse.
package gb_apu_pkg;

    localparam int FS_STEPS = 8;

    typedef logic [2:0] fs_step_t;

    localparam logic [FS_STEPS-1:0] LEN_MASK   = 8'b0101_0101;
    localparam logic [FS_STEPS-1:0] SWEEP_MASK = 8'b0100_0100;
    localparam logic [FS_STEPS-1:0] ENV_MASK   = 8'b1000_0000;

    typedef struct packed {
        logic length;
        logic sweep;
        logic vol_env;
    } fs_pulse_t;

    function automatic fs_pulse_t decode_step(input fs_step_t s);
        fs_pulse_t p;
        p.length  = LEN_MASK[s];
        p.sweep   = SWEEP_MASK[s];
        p.vol_env = ENV_MASK[s];
        return p;
    endfunction

endpackage

// File: rtl/gb_apu_div_tick.sv
// Produces the 512 Hz base event, either from an internal clk prescaler
// or from the falling edge of the timer DIV bit.
module gb_apu_div_tick #(
    parameter int EXT_DIV = 0,
    parameter int DIVIDER = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic apu_en,
    input  logic div_bit,
    output logic base_event
);

    // Sampled even while powered down, so the first edge after power-up
    // is judged against the real previous level.
    logic div_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_prev <= 1'b0;
        end else begin
            div_prev <= div_bit;
        end
    end

    generate
        if (EXT_DIV != 0) begin : g_ext
            assign base_event = div_prev & ~div_bit & apu_en;
        end else begin : g_int
            localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

            logic [CW-1:0] count;
            logic          at_wrap;
            logic          unused_div_prev;

            assign at_wrap         = (count == CW'(DIVIDER - 1));
            assign base_event      = apu_en & at_wrap;
            assign unused_div_prev = div_prev;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    count <= '0;
                end else if (!apu_en || at_wrap) begin
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// APU frame sequencer: 8-step counter turning the base event into
// single-cycle length / sweep / envelope clock pulses.
module gb_apu_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int EXT_DIV = 0,
    parameter int DIVIDER = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_en,
    input  logic       div_bit,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_vol_env,
    output logic [2:0] step,
    output logic       length_skip_next
);

    logic      base_event;
    fs_step_t  step_q;
    fs_pulse_t pulse_q;

    gb_apu_div_tick #(
        .EXT_DIV (EXT_DIV),
        .DIVIDER (DIVIDER)
    ) u_div_tick (
        .clk        (clk),
        .reset      (reset),
        .apu_en     (apu_en),
        .div_bit    (div_bit),
        .base_event (base_event)
    );

    // Power-down takes priority over a coincident event: no pulse, step 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q  <= '0;
            pulse_q <= '0;
        end else if (!apu_en) begin
            step_q  <= '0;
            pulse_q <= '0;
        end else if (base_event) begin
            pulse_q <= decode_step(step_q);
            step_q  <= step_q + 3'd1;
        end else begin
            pulse_q <= '0;
        end
    end

    assign clk_length_ctr   = pulse_q.length;
    assign clk_sweep        = pulse_q.sweep;
    assign clk_vol_env      = pulse_q.vol_env;
    assign step             = step_q;
    assign length_skip_next = step_q[0];

endmodule
